// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - 8N1 UART transmitter with baud divider, abort and back-to-back framing
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 1,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 tx_out,
    output logic                 tx_busy,
    output logic                 tx_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // A one-clock bit period still needs a 1-bit counter so the compare stays legal.
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_BITS) + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [BAUD_W-1:0]      baud_cnt;
    logic [BAUD_W-1:0]      baud_nxt;
    logic [BIT_W-1:0]       bit_cnt;
    logic [BIT_W-1:0]       bit_nxt;
    logic [DATA_BITS-1:0]   shift_reg;
    logic [DATA_BITS-1:0]   shift_nxt;
    logic                   tx_nxt;
    logic                   baud_end;

    assign baud_end = (baud_cnt == BAUD_LAST);
    assign tx_busy  = (state != IDLE);
    assign tx_done  = (state == STOP) && baud_end;

    // Next-state, counter and shift-register logic; enable aborts everything back to IDLE.
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_cnt;
        shift_nxt = shift_reg;
        if (enable) begin
            state_nxt = IDLE;
            baud_nxt  = '0;
            bit_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = START;
                        shift_nxt = data_in;
                        bit_nxt   = '0;
                        baud_nxt  = '0;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud_nxt  = '0;
                        state_nxt = DATA;
                    end else begin
                        baud_nxt = baud_cnt + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_nxt  = '0;
                        shift_nxt = shift_reg >> 1;
                        bit_nxt   = bit_cnt + BIT_W'(1);
                        if (bit_cnt == BIT_LAST) begin
                            state_nxt = STOP;
                        end
                    end else begin
                        baud_nxt = baud_cnt + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud_nxt = '0;
                        bit_nxt  = '0;
                        // A held request chains the next frame with no idle gap.
                        if (start) begin
                            state_nxt = START;
                            shift_nxt = data_in;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        baud_nxt = baud_cnt + BAUD_W'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Line level for the upcoming cycle, so tx_out moves on the same edge as the state.
    always_comb begin
        tx_nxt = 1'b1;
        case (state_nxt)
            IDLE:    tx_nxt = 1'b1;
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shift_nxt[0];
            STOP:    tx_nxt = 1'b1;
            default: tx_nxt = 1'b1;
        endcase
    end

    // State, counters, shift register and registered serial output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            tx_out    <= 1'b1;
        end else begin
            state     <= state_nxt;
            baud_cnt  <= baud_nxt;
            bit_cnt   <= bit_nxt;
            shift_reg <= shift_nxt;
            tx_out    <= tx_nxt;
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - self-checking bench for uart_transmitter
module tb_uart_transmitter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en1, start1, en4, start4;
    logic [7:0] d1, d4;
    logic       tx1, busy1, done1, tx4, busy4, done4;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    uart_transmitter #(.CLKS_PER_BIT(1), .DATA_BITS(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(en1), .start(start1), .data_in(d1),
        .tx_out(tx1), .tx_busy(busy1), .tx_done(done1)
    );

    uart_transmitter #(.CLKS_PER_BIT(4), .DATA_BITS(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .enable(en4), .start(start4), .data_in(d4),
        .tx_out(tx4), .tx_busy(busy4), .tx_done(done4)
    );

    // Reference: line level at clock k of a frame (start bit, LSB-first data, stop bit).
    function automatic logic exp_line(input logic [7:0] d, input int k, input int cpb);
        int b;
        b = k / cpb;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends one frame on dut1 (sel=0) or dut4 (sel=1), checking every clock of it.
    task automatic frame(input int sel, input logic [7:0] d, input logic [7:0] d_mid,
                         input bit hold, input string tag);
        int cpb;
        int n;
        cpb = (sel != 0) ? 4 : 1;
        n   = 10 * cpb;
        if (sel != 0) begin en4 = 1'b0; start4 = 1'b1; d4 = d; end
        else          begin en1 = 1'b0; start1 = 1'b1; d1 = d; end
        for (int k = 0; k < n; k++) begin
            step();
            if (k == 0 && !hold) begin
                if (sel != 0) start4 = 1'b0; else start1 = 1'b0;
            end
            if (k == n / 2) begin
                if (sel != 0) d4 = d_mid; else d1 = d_mid;
            end
            check($sformatf("%s_tx_k%0d", tag, k), (sel != 0) ? tx4 : tx1, exp_line(d, k, cpb));
            check($sformatf("%s_busy_k%0d", tag, k), (sel != 0) ? busy4 : busy1, 1'b1);
            check($sformatf("%s_done_k%0d", tag, k), (sel != 0) ? done4 : done1, (k == n - 1));
        end
    endtask

    task automatic check_idle(input int sel, input string tag);
        check({tag, "_tx"},   (sel != 0) ? tx4 : tx1,     1'b1);
        check({tag, "_busy"}, (sel != 0) ? busy4 : busy1, 1'b0);
        check({tag, "_done"}, (sel != 0) ? done4 : done1, 1'b0);
    endtask

    initial begin
        logic [7:0] r;
        logic [7:0] m;

        // Reset held with a pending request: line must stay idle.
        rst_n = 1'b0;
        en1 = 1'b0; start1 = 1'b1; d1 = 8'hC9;
        en4 = 1'b0; start4 = 1'b1; d4 = 8'h55;
        repeat (3) step();
        check_idle(0, "reset1");
        check_idle(1, "reset4");

        // Release with enable high: still idle despite start.
        en1 = 1'b1; en4 = 1'b1;
        rst_n = 1'b1;
        repeat (3) step();
        check_idle(0, "held1");
        check_idle(1, "held4");

        // Single directed frame, then back to idle.
        frame(0, 8'hC9, 8'hC9, 1'b0, "c9");
        step();
        check_idle(0, "c9_after");

        // Held start: continuous frames with no gap, last one releases start.
        frame(0, 8'hC9, 8'hC9, 1'b1, "b2b0");
        r = 8'($urandom_range(0, 255));
        frame(0, r, r, 1'b1, "b2b1");
        r = 8'($urandom_range(0, 255));
        frame(0, r, r, 1'b0, "b2b2");
        step();
        check_idle(0, "b2b_after");

        // Abort during data bit 3: next edge idle, no done.
        r = 8'($urandom_range(0, 255));
        en1 = 1'b0; start1 = 1'b1; d1 = r;
        for (int k = 0; k <= 4; k++) begin
            step();
            if (k == 0) start1 = 1'b0;
            check($sformatf("abort_tx_k%0d", k), tx1, exp_line(r, k, 1));
            check($sformatf("abort_done_k%0d", k), done1, 1'b0);
        end
        en1 = 1'b1; start1 = 1'b1;
        step();
        check_idle(0, "abort_edge");
        step();
        check_idle(0, "abort_prio");
        r = 8'($urandom_range(0, 255));
        frame(0, r, r, 1'b0, "post_abort");
        step();
        check_idle(0, "post_abort_after");

        // Data changed mid-frame must not disturb the frame in flight.
        frame(0, 8'hC9, 8'h00, 1'b0, "mid_c9");
        step();
        r = 8'($urandom_range(0, 255));
        m = ~r;
        frame(0, r, m, 1'b0, "mid_rand");
        step();
        check_idle(0, "mid_after");

        // Asynchronous reset mid-frame: immediate idle, no resume afterwards.
        en1 = 1'b0; start1 = 1'b1; d1 = 8'hC9;
        step();
        start1 = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        check_idle(0, "async_rst");
        step();
        rst_n = 1'b1;
        repeat (2) step();
        check_idle(0, "async_norsm");

        // Four clocks per bit.
        frame(1, 8'h55, 8'h55, 1'b0, "cpb4_55");
        step();
        check_idle(1, "cpb4_after");
        r = 8'($urandom_range(0, 255));
        frame(1, r, 8'($urandom_range(0, 255)), 1'b0, "cpb4_rand");
        step();
        check_idle(1, "cpb4_rand_after");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
